fsm: RTL and testbench
======================

// Module: fsm
// PURPOSE
//  Main control unit of the multicycle RISC-V datapath. Moore FSM that steps
//  fetch/decode/execute/memory/writeback states per instruction and drives all
//  datapath mux selects, write enables and ALU-control hints from current state.
//  Sits between the instruction register (opcode field) and the datapath.
// PARAMETERS
//  none; state, opcode and ALUOp/ALUSrcB encodings come from fsm_pkg.
// PORTS
//  clk          in   1  system clock, rising-edge active
//  reset        in   1  asynchronous, active-low reset (0 = reset); single clock domain
//  opcode       in   7  instr[6:0] from instruction register
//  RegWrite     out  1  register file write enable
//  ALUSrcA      out  1  ALU A select: 0=PC, 1=rs1 register A
//  MemRead      out  1  memory read enable
//  MemWrite     out  1  memory write enable
//  MemtoReg     out  1  write-back select: 0=ALUOut, 1=MDR
//  IorD         out  1  memory address select: 0=PC, 1=ALUOut
//  IRWrite      out  1  instruction register load enable
//  PCWrite      out  1  unconditional PC write
//  PCWriteCond  out  1  PC write qualified by ALU zero (branch)
//  PCSource     out  1  PC source: 0=ALU result, 1=ALUOut
//  ALUOp        out  2  00=add, 01=subtract/compare, 10=use funct fields
//  ALUSrcB      out  2  00=register B, 01=constant 4, 10=immediate
// BEHAVIOUR
//  - State register updates on rising clk; reset low forces S0 immediately.
//  - Outputs purely from state (Moore); every unlisted output is 0.
//  - S0 FETCH:   MemRead=1 IRWrite=1 PCWrite=1 ALUSrcB=01 (ALUSrcA,IorD,ALUOp,PCSource=0) -> S1
//  - S1 DECODE:  ALUSrcA=0 ALUSrcB=10 ALUOp=00 (branch target into ALUOut); opcode
//                sampled this cycle: 0000011 lw / 0100011 sw -> S2; 0110011 R -> S6;
//                1100011 beq -> S8; any other opcode -> S0 (illegal, dropped)
//  - S2 MEMADR:  ALUSrcA=1 ALUSrcB=10 ALUOp=00; lw -> S3, sw -> S5
//  - S3 MEMRD:   MemRead=1 IorD=1 -> S4
//  - S4 MEMWB:   RegWrite=1 MemtoReg=1 -> S0
//  - S5 MEMWR:   MemWrite=1 IorD=1 -> S0
//  - S6 EXEC:    ALUSrcA=1 ALUSrcB=00 ALUOp=10 -> S7
//  - S7 RCOMP:   RegWrite=1 MemtoReg=0 -> S0
//  - S8 BRANCH:  ALUSrcA=1 ALUSrcB=00 ALUOp=01 PCWriteCond=1 PCSource=1 -> S0
//  - Latency: R=4, lw=5, sw=4, beq=3 cycles.
//  - During reset outputs equal S0 values; first post-reset edge moves to S1.
//  - Reset asserted mid-instruction aborts it; no partial write beyond current cycle.
//  - Unreachable state codes return to S0 with all outputs 0.
//  - opcode only matters in S1 and S2; changes elsewhere ignored.
// CONFIGURATION
//  ITYPE_EN defined: opcode 0010011 in S1 -> S9 EXECI (ALUSrcA=1 ALUSrcB=10
//  ALUOp=10) -> S7. Undefined: 0010011 is illegal -> S0; S9 not present.
// STRUCTURE
//  fsm_pkg: state enum S0..S9, opcode constants (OP_LW, OP_SW, OP_RTYPE,
//  OP_BEQ, OP_ITYPE), ALUOp and ALUSrcB encodings.
//  Sub-module fsm_out_dec: combinational state -> control-word decoder;
//  fsm holds state register and next-state logic.
// TESTING
//  - reset low -> S0 outputs: MemRead=1 IRWrite=1 PCWrite=1 ALUSrcB=01 ALUOp=00 IorD=0
//  - release, opcode=0110011 -> S1 (ALUSrcA=0 ALUSrcB=10), S6 (ALUSrcA=1 ALUSrcB=00
//    ALUOp=10), S7 (RegWrite=1 MemtoReg=0), then S0 fetch outputs again
//  - opcode=0000011 -> S2,S3 (MemRead=1 IorD=1), S4 (RegWrite=1 MemtoReg=1), S0
//  - opcode=0100011 -> S2, S5 (MemWrite=1 IorD=1, RegWrite=0), S0
//  - opcode=1100011 -> S8 PCWriteCond=1 PCSource=1 ALUOp=01; opcode=1111111 -> S0 after S1
//  - reset pulsed low in S3 -> S0 outputs same cycle; ITYPE_EN: 0010011 -> S9 ALUSrcB=10 ALUOp=10 -> S7

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared types and encodings for the multicycle RISC-V main control FSM.
// Optional I-type ALU support is enabled by defining ITYPE_EN.
package fsm_pkg;

    typedef enum logic [3:0] {
        S0 = 4'd0,  // FETCH
        S1 = 4'd1,  // DECODE
        S2 = 4'd2,  // MEMADR
        S3 = 4'd3,  // MEMRD
        S4 = 4'd4,  // MEMWB
        S5 = 4'd5,  // MEMWR
        S6 = 4'd6,  // EXEC
        S7 = 4'd7,  // RCOMP
        S8 = 4'd8,  // BRANCH
        S9 = 4'd9   // EXECI
    } stateT;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluOpT;

    typedef enum logic [1:0] {
        SRCB_REG  = 2'b00,
        SRCB_FOUR = 2'b01,
        SRCB_IMM  = 2'b10
    } aluSrcBT;

    typedef struct packed {
        logic    regWrite;
        logic    aluSrcA;
        logic    memRead;
        logic    memWrite;
        logic    memtoReg;
        logic    iorD;
        logic    irWrite;
        logic    pcWrite;
        logic    pcWriteCond;
        logic    pcSource;
        aluOpT   aluOp;
        aluSrcBT aluSrcB;
    } ctrlT;

    localparam ctrlT CTRL_NONE = '0;

endpackage

// File: rtl/fsm_out_dec.sv
// Combinational decoder from FSM state to the datapath control word (Moore outputs).
// Decodes the EXECI state only when ITYPE_EN is defined.
module fsm_out_dec
    import fsm_pkg::*;
(
    input  stateT state,
    output ctrlT  ctrl
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        ctrl = CTRL_NONE;
        case (state)
            S0: begin
                ctrl.memRead = 1'b1;
                ctrl.irWrite = 1'b1;
                ctrl.pcWrite = 1'b1;
                ctrl.aluSrcB = SRCB_FOUR;
            end
            S1: ctrl.aluSrcB = SRCB_IMM;
            S2: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
            end
            S3: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            S4: begin
                ctrl.regWrite = 1'b1;
                ctrl.memtoReg = 1'b1;
            end
            S5: begin
                ctrl.memWrite = 1'b1;
                ctrl.iorD     = 1'b1;
            end
            S6: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluOp   = ALUOP_FUNCT;
            end
            S7: ctrl.regWrite = 1'b1;
            S8: begin
                ctrl.aluSrcA     = 1'b1;
                ctrl.aluOp       = ALUOP_SUB;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSource    = 1'b1;
            end
`ifdef ITYPE_EN
            S9: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluOp   = ALUOP_FUNCT;
                ctrl.aluSrcB = SRCB_IMM;
            end
`else
            // Without I-type support S9 is just another unreachable code.
            S9: ctrl = CTRL_NONE;
`endif
            default: ctrl = CTRL_NONE;
        endcase
    end

endmodule

// File: rtl/fsm.sv
// Main control FSM of the multicycle RISC-V datapath: state register plus next-state logic.
// Defining ITYPE_EN adds the I-type ALU path S1 -> S9 -> S7.
module fsm
    import fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCSource,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB
);

    stateT state;
    stateT stateNext;
    ctrlT  ctrl;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S0;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = S0;
        case (state)
            S0: stateNext = S1;
            S1: begin
                case (opcode)
                    OP_LW, OP_SW: stateNext = S2;
                    OP_RTYPE:     stateNext = S6;
                    OP_BEQ:       stateNext = S8;
`ifdef ITYPE_EN
                    OP_ITYPE:     stateNext = S9;
`endif
                    default:      stateNext = S0;
                endcase
            end
            S2: begin
                if (opcode == OP_LW)      stateNext = S3;
                else if (opcode == OP_SW) stateNext = S5;
                else                      stateNext = S0;
            end
            S3: stateNext = S4;
            S6: stateNext = S7;
`ifdef ITYPE_EN
            S9: stateNext = S7;
`else
            S9: stateNext = S0;
`endif
            default: stateNext = S0;  // S4, S5, S7, S8 and unreachable codes
        endcase
    end

    fsm_out_dec uDec (
        .state (state),
        .ctrl  (ctrl)
    );

    assign RegWrite    = ctrl.regWrite;
    assign ALUSrcA     = ctrl.aluSrcA;
    assign MemRead     = ctrl.memRead;
    assign MemWrite    = ctrl.memWrite;
    assign MemtoReg    = ctrl.memtoReg;
    assign IorD        = ctrl.iorD;
    assign IRWrite     = ctrl.irWrite;
    assign PCWrite     = ctrl.pcWrite;
    assign PCWriteCond = ctrl.pcWriteCond;
    assign PCSource    = ctrl.pcSource;
    assign ALUOp       = ctrl.aluOp;
    assign ALUSrcB     = ctrl.aluSrcB;

endmodule

// File: tb/tb_fsm.sv
// Self-checking bench for fsm: directed vector table, reset corner cases, and
// random instruction streams checked against a per-instruction control-word model.
module tb_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic       RegWrite, ALUSrcA, MemRead, MemWrite, MemtoReg, IorD;
    logic       IRWrite, PCWrite, PCWriteCond, PCSource;
    logic [1:0] ALUOp, ALUSrcB;

    fsm dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IorD        (IorD),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp),
        .ALUSrcB     (ALUSrcB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] LW    = 7'b0000011;
    localparam logic [6:0] SW    = 7'b0100011;
    localparam logic [6:0] RTYPE = 7'b0110011;
    localparam logic [6:0] BEQ   = 7'b1100011;
    localparam logic [6:0] ITYPE = 7'b0010011;

    // Observed control word: {RegWrite,ALUSrcA,MemRead,MemWrite,MemtoReg,IorD,
    //                         IRWrite,PCWrite,PCWriteCond,PCSource,ALUOp,ALUSrcB}
    logic [13:0] act;
    assign act = {RegWrite, ALUSrcA, MemRead, MemWrite, MemtoReg, IorD,
                  IRWrite, PCWrite, PCWriteCond, PCSource, ALUOp, ALUSrcB};

    function automatic logic [13:0] w(input logic rw, input logic asa, input logic mr,
                                      input logic mw, input logic m2r, input logic iord,
                                      input logic irw, input logic pcw, input logic pcwc,
                                      input logic pcs, input logic [1:0] aop,
                                      input logic [1:0] asb);
        return {rw, asa, mr, mw, m2r, iord, irw, pcw, pcwc, pcs, aop, asb};
    endfunction

    logic [13:0] wFetch, wDecode, wMemAdr, wMemRd, wMemWb, wMemWr;
    logic [13:0] wExec, wRComp, wBranch, wExecI;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [6:0]        op;
        logic [2:0]        len;
        logic [5:0][13:0]  exp;
    } vecT;

    vecT tbl[6];

    function automatic vecT mkVec(input logic [6:0] op, input logic [2:0] len,
                                  input logic [13:0] e0, input logic [13:0] e1,
                                  input logic [13:0] e2, input logic [13:0] e3,
                                  input logic [13:0] e4);
        vecT v;
        v.op     = op;
        v.len    = len;
        v.exp[0] = e0;
        v.exp[1] = e1;
        v.exp[2] = e2;
        v.exp[3] = e3;
        v.exp[4] = e4;
        v.exp[5] = '0;
        return v;
    endfunction

    // Reference model: one instruction is fetch, decode, then an opcode-dependent tail.
    logic [13:0] expQ[$];

    task automatic buildModel(input logic [6:0] op);
        expQ = {};
        expQ.push_back(wFetch);
        expQ.push_back(wDecode);
        if (op == LW) begin
            expQ.push_back(wMemAdr); expQ.push_back(wMemRd); expQ.push_back(wMemWb);
        end else if (op == SW) begin
            expQ.push_back(wMemAdr); expQ.push_back(wMemWr);
        end else if (op == RTYPE) begin
            expQ.push_back(wExec); expQ.push_back(wRComp);
        end else if (op == BEQ) begin
            expQ.push_back(wBranch);
`ifdef ITYPE_EN
        end else if (op == ITYPE) begin
            expQ.push_back(wExecI); expQ.push_back(wRComp);
`endif
        end
    endtask

    // Called at a negedge with the DUT in fetch; opcode is only held where it matters.
    task automatic runModel(input logic [6:0] op);
        bit memOp;
        memOp = (op == LW) || (op == SW);
        buildModel(op);
        for (int i = 0; i < expQ.size(); i++) begin
            check($sformatf("rand op=%b step%0d", op, i), act, expQ[i]);
            if (i == 1 || (i == 2 && memOp)) opcode = op;
            else                             opcode = 7'($urandom);
            @(negedge clk);
        end
    endtask

    initial begin
        wFetch  = w(0,0,1,0,0,0,1,1,0,0,2'b00,2'b01);
        wDecode = w(0,0,0,0,0,0,0,0,0,0,2'b00,2'b10);
        wMemAdr = w(0,1,0,0,0,0,0,0,0,0,2'b00,2'b10);
        wMemRd  = w(0,0,1,0,0,1,0,0,0,0,2'b00,2'b00);
        wMemWb  = w(1,0,0,0,1,0,0,0,0,0,2'b00,2'b00);
        wMemWr  = w(0,0,0,1,0,1,0,0,0,0,2'b00,2'b00);
        wExec   = w(0,1,0,0,0,0,0,0,0,0,2'b10,2'b00);
        wRComp  = w(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00);
        wBranch = w(0,1,0,0,0,0,0,0,1,1,2'b01,2'b00);
        wExecI  = w(0,1,0,0,0,0,0,0,0,0,2'b10,2'b10);

        tbl[0] = mkVec(RTYPE,     3'd4, wFetch, wDecode, wExec,   wRComp, '0);
        tbl[1] = mkVec(LW,        3'd5, wFetch, wDecode, wMemAdr, wMemRd, wMemWb);
        tbl[2] = mkVec(SW,        3'd4, wFetch, wDecode, wMemAdr, wMemWr, '0);
        tbl[3] = mkVec(BEQ,       3'd3, wFetch, wDecode, wBranch, '0,     '0);
        tbl[4] = mkVec(7'b1111111, 3'd2, wFetch, wDecode, '0,     '0,     '0);
`ifdef ITYPE_EN
        tbl[5] = mkVec(ITYPE,     3'd4, wFetch, wDecode, wExecI,  wRComp, '0);
`else
        tbl[5] = mkVec(ITYPE,     3'd2, wFetch, wDecode, '0,      '0,     '0);
`endif

        // Reset held across several edges keeps fetch outputs.
        reset  = 1'b0;
        opcode = RTYPE;
        #1 check("reset_initial", act, wFetch);
        repeat (3) @(negedge clk);
        check("reset_held", act, wFetch);
        reset = 1'b1;

        // Directed table.
        for (int v = 0; v < 6; v++) begin
            for (int j = 0; j < int'(tbl[v].len); j++) begin
                check($sformatf("vec%0d op=%b step%0d", v, tbl[v].op, j), act, tbl[v].exp[j]);
                opcode = tbl[v].op;
                @(negedge clk);
            end
        end
        check("table_return_fetch", act, wFetch);

        // Reset pulsed while in MEMRD aborts the load immediately.
        opcode = LW;
        check("abort_fetch", act, wFetch);  @(negedge clk);
        check("abort_decode", act, wDecode); @(negedge clk);
        check("abort_memadr", act, wMemAdr); @(negedge clk);
        check("abort_memrd", act, wMemRd);
        #2 reset = 1'b0;
        #1 check("abort_reset_same_cycle", act, wFetch);
        @(negedge clk);
        check("abort_no_memwb", act, wFetch);
        reset = 1'b1;
        opcode = BEQ;
        @(negedge clk);
        check("abort_first_edge_decode", act, wDecode);
        @(negedge clk);
        check("abort_then_branch", act, wBranch);
        @(negedge clk);

        // Random instruction stream.
        for (int n = 0; n < 300; n++) begin
            logic [6:0] op;
            case ($urandom_range(0, 5))
                0: op = LW;
                1: op = SW;
                2: op = RTYPE;
                3: op = BEQ;
                4: op = ITYPE;
                default: op = 7'($urandom);
            endcase
            runModel(op);
        end
        check("final_fetch", act, wFetch);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
